// File: rtl/slc3_pkg.sv
// Shared definitions for the SLC-3 memory/IO bridge.
//   IO_ADDR        - memory-mapped switch/hex-display word
//   WORD_W         - CPU data and address width
//   MEM_ADDR_W     - board SRAM address width
//   bridge_state_t - bridge FSM states
package slc3_pkg;

  localparam logic [15:0] IO_ADDR    = 16'hFFFF;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned MEM_ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE,
    MEM_ACC,
    DONE
  } bridge_state_t;

endpackage

// File: rtl/sw_sync.sv
// Two-flop synchronizer for asynchronous board inputs.
//   Clk   - system clock
//   Reset - synchronous active-high reset, both flops clear to 0
//   d_i   - asynchronous input bus
//   q_o   - synchronized output, two cycles behind d_i
module sw_sync #(
  parameter int unsigned Width = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_io_bridge.sv
// LC-3 bus bridge to board SRAM plus the memory-mapped I/O word at IO_ADDR.
// One access at a time; SRAM accesses hold active-low strobes for WAIT_CYCLES
// cycles, I/O accesses complete in one cycle. Completion is a one-cycle ready.
// Optional feature: define SW_SYNC_EN to pass switches through a two-flop
// synchronizer before the I/O read mux.
// Ports:
//   Clk, Reset              - clock, synchronous active-high reset
//   req, we, addr, wdata    - CPU request (level), direction, word address, data
//   rdata, ready            - read data (held), completion pulse
//   mem_addr, mem_*_n       - SRAM address and active-low strobes
//   mem_dout, mem_dout_en   - SRAM write data and bus-drive enable
//   mem_din                 - SRAM read data
//   switches, hex_val       - board switches in, hex display word out
module mem_io_bridge
  import slc3_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [WORD_W-1:0]     addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata,
  output logic                  ready,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_ce_n,
  output logic                  mem_oe_n,
  output logic                  mem_we_n,
  output logic                  mem_ub_n,
  output logic                  mem_lb_n,
  output logic [WORD_W-1:0]     mem_dout,
  output logic                  mem_dout_en,
  input  logic [WORD_W-1:0]     mem_din,
  input  logic [WORD_W-1:0]     switches,
  output logic [WORD_W-1:0]     hex_val
);

  // Counter counts down to 0, so an access spends WAIT_CYCLES cycles in MEM_ACC.
  localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

  logic [WORD_W-1:0] sw_val;

`ifdef SW_SYNC_EN
  sw_sync #(
    .Width(WORD_W)
  ) u_sw_sync (
    .Clk  (Clk),
    .Reset(Reset),
    .d_i  (switches),
    .q_o  (sw_val)
  );
`else
  assign sw_val = switches;
`endif

  bridge_state_t     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [WORD_W-1:0] hex_q, hex_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      hex_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          wdata_d = wdata;
          if (addr == IO_ADDR) begin
            state_d = DONE;
            if (we) begin
              hex_d = wdata;
            end else begin
              rdata_d = sw_val;
            end
          end else begin
            // mem_addr only follows SRAM accesses; I/O accesses leave it alone.
            addr_d  = addr;
            cnt_d   = CntLoad;
            state_d = MEM_ACC;
          end
        end
      end
      MEM_ACC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            rdata_d = mem_din;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  logic mem_acc;
  assign mem_acc = (state_q == MEM_ACC);

  assign mem_ce_n    = ~mem_acc;
  assign mem_ub_n    = ~mem_acc;
  assign mem_lb_n    = ~mem_acc;
  assign mem_oe_n    = ~(mem_acc & ~we_q);
  assign mem_we_n    = ~(mem_acc & we_q);
  assign mem_dout_en = mem_acc & we_q;
  assign mem_dout    = mem_dout_en ? wdata_q : '0;
  assign mem_addr    = {{(MEM_ADDR_W - WORD_W){1'b0}}, addr_q};
  assign ready       = (state_q == DONE);
  assign rdata       = rdata_q;
  assign hex_val     = hex_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;

  localparam int unsigned WAIT = 2;

  logic        Clk = 1'b0;
  logic        Reset, req, we;
  logic [15:0] addr, wdata, rdata, mem_dout, mem_din, switches, hex_val;
  logic [19:0] mem_addr;
  logic        ready, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n, mem_dout_en;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mem_io_bridge #(
    .WAIT_CYCLES(WAIT)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .mem_addr   (mem_addr),
    .mem_ce_n   (mem_ce_n),
    .mem_oe_n   (mem_oe_n),
    .mem_we_n   (mem_we_n),
    .mem_ub_n   (mem_ub_n),
    .mem_lb_n   (mem_lb_n),
    .mem_dout   (mem_dout),
    .mem_dout_en(mem_dout_en),
    .mem_din    (mem_din),
    .switches   (switches),
    .hex_val    (hex_val)
  );

  // Small SRAM model: 256 words indexed by the low address byte, unwritten = DEAD.
  logic [15:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
  always @(posedge Clk) if (!mem_ce_n && !mem_we_n) mem[mem_addr[7:0]] <= mem_dout;
  assign mem_din = mem[mem_addr[7:0]];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] sw;
    int          lat;
    logic [15:0] rdata;
    logic [15:0] hex;
    int          stb;
    int          wec;
    int          oec;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [4:0] strobes;
  assign strobes = {mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n};

  task automatic run_vec(input int idx, input vec_t v);
    int lat = 0, stb = 0, wec = 0, oec = 0, en = 0, addr_bad = 0, dout_bad = 0;
    switches = v.sw;
    repeat (3) @(negedge Clk);
    we = v.we; addr = v.addr; wdata = v.wdata; req = 1'b1;
    @(posedge Clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (!mem_ce_n) begin
        stb++;
        if (mem_addr !== {4'h0, v.addr}) addr_bad++;
      end
      if (!mem_we_n) begin
        wec++;
        if (mem_dout !== v.wdata) dout_bad++;
      end
      if (!mem_oe_n) oec++;
      if (mem_dout_en) en++;
      if (ready) begin
        lat = c;
        break;
      end
    end
    req = 1'b0;
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d rdata", idx), {16'h0, rdata}, {16'h0, v.rdata});
    chk($sformatf("v%0d hex_val", idx), {16'h0, hex_val}, {16'h0, v.hex});
    chk($sformatf("v%0d ce cycles", idx), stb, v.stb);
    chk($sformatf("v%0d we cycles", idx), wec, v.wec);
    chk($sformatf("v%0d dout_en cycles", idx), en, v.wec);
    chk($sformatf("v%0d oe cycles", idx), oec, v.oec);
    chk($sformatf("v%0d mem_addr bad", idx), addr_bad, 0);
    chk($sformatf("v%0d mem_dout bad", idx), dout_bad, 0);
    @(negedge Clk);
  endtask

  // Hold req high with one address; report the first two ready pulse cycles.
  task automatic b2b(input string name, input logic [15:0] a, input int exp_gap,
                     input logic [15:0] exp_rd);
    int r1 = -1, r2 = -1, overlap = 0;
    we = 1'b0; addr = a; req = 1'b1;
    @(posedge Clk);
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clk);
      if (ready && !mem_ce_n) overlap++;
      if (ready) begin
        if (r1 < 0) r1 = c;
        else begin
          r2 = c;
          break;
        end
      end
    end
    req = 1'b0;
    chk({name, " first ready"}, r1, (exp_gap == 2) ? 1 : WAIT + 1);
    chk({name, " ready gap"}, r2 - r1, exp_gap);
    chk({name, " strobe/ready overlap"}, overlap, 0);
    chk({name, " rdata"}, {16'h0, rdata}, {16'h0, exp_rd});
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //             we    addr      wdata     sw        lat rdata     hex      stb wec oec
    vecs[0] = '{1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 1, 16'h0000, 16'hBEEF, 0, 0, 0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0000, 16'h1234, 1, 16'h1234, 16'hBEEF, 0, 0, 0};
    vecs[2] = '{1'b1, 16'h0040, 16'hA5A5, 16'h1234, 3, 16'h1234, 16'hBEEF, 2, 2, 0};
    vecs[3] = '{1'b0, 16'h0040, 16'h0000, 16'h1234, 3, 16'hA5A5, 16'hBEEF, 2, 0, 2};
    vecs[4] = '{1'b1, 16'h1234, 16'h0F0F, 16'h1234, 3, 16'hA5A5, 16'hBEEF, 2, 2, 0};
    vecs[5] = '{1'b0, 16'h0041, 16'h0000, 16'h1234, 3, 16'hDEAD, 16'hBEEF, 2, 0, 2};
    vecs[6] = '{1'b0, 16'h1234, 16'h0000, 16'h1234, 3, 16'h0F0F, 16'hBEEF, 2, 0, 2};
    vecs[7] = '{1'b0, 16'hFFFE, 16'h0000, 16'h1234, 3, 16'hDEAD, 16'hBEEF, 2, 0, 2};
    vecs[8] = '{1'b1, 16'hFFFF, 16'h0000, 16'hABCD, 1, 16'hDEAD, 16'h0000, 0, 0, 0};
    vecs[9] = '{1'b0, 16'hFFFF, 16'h5555, 16'hABCD, 1, 16'hABCD, 16'h0000, 0, 0, 0};

    Reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; switches = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      chk($sformatf("idle%0d strobes", c), {27'h0, strobes}, 32'h1F);
      chk($sformatf("idle%0d ready", c), {31'h0, ready}, 0);
    end
    chk("reset hex_val", {16'h0, hex_val}, 0);
    chk("reset rdata", {16'h0, rdata}, 0);
    chk("reset mem_addr", {12'h0, mem_addr}, 0);
    chk("reset mem_dout_en", {31'h0, mem_dout_en}, 0);
    chk("reset mem_dout", {16'h0, mem_dout}, 0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset during the second MEM_ACC cycle of a write.
    run_vec(10, '{1'b1, 16'hFFFF, 16'h1111, 16'hABCD, 1, 16'hABCD, 16'h1111, 0, 0, 0});
    we = 1'b1; addr = 16'h0080; wdata = 16'h7777; req = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("abort cyc1 ce_n", {31'h0, mem_ce_n}, 0);
    @(negedge Clk);
    chk("abort cyc2 we_n", {31'h0, mem_we_n}, 0);
    Reset = 1'b1; req = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort strobes", {27'h0, strobes}, 32'h1F);
    chk("abort ready", {31'h0, ready}, 0);
    chk("abort hex_val", {16'h0, hex_val}, 0);
    chk("abort rdata", {16'h0, rdata}, 0);
    chk("abort dout_en", {31'h0, mem_dout_en}, 0);
    begin
      int busy = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge Clk);
        if (ready || !mem_ce_n) busy++;
      end
      chk("abort quiet after", busy, 0);
    end

    // Reset and req together: request dropped.
    Reset = 1'b1; req = 1'b1; we = 1'b0; addr = 16'h0040;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0; req = 1'b0;
    begin
      int busy = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge Clk);
        if (ready || !mem_ce_n) busy++;
      end
      chk("reset+req dropped", busy, 0);
    end

    b2b("b2b sram", 16'h0040, WAIT + 2, 16'hA5A5);
    switches = 16'h3C3C;
    repeat (3) @(negedge Clk);
    b2b("b2b io", 16'hFFFF, 2, 16'h3C3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Bus-side memory/IO bridge between the LC-3 processor and the board SRAM or test memory. It accepts one read or write request at a time and runs a fixed-wait-state SRAM access with active-low strobes. The memory-mapped I/O word at 16'hFFFF is decoded locally: reads return the switches, and writes latch the hex display register that feeds the four HexDriver instances.

## Interface
Parameters:
- WAIT_CYCLES, default 2: number of cycles the SRAM strobes are held per access; legal range 1..15 (0 is illegal).

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req  in  1  CPU access request, level-sensitive.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  16  CPU word address.
- wdata  in  16  CPU write data.
- rdata  out  16  read data to CPU.
- ready  out  1  one-cycle completion pulse.
- mem_addr  out  20  SRAM address = {4'b0, latched addr}.
- mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n  out  1 each  SRAM strobes, active low.
- mem_dout  out  16  SRAM write data.
- mem_dout_en  out  1  tri-state enable for the shared data bus.
- mem_din  in  16  SRAM read data.
- switches  in  16  board switches S.
- hex_val  out  16  display word; nibble n drives HEXn.

## Operation
- FSM states:
  - IDLE: ready=0, all strobes deasserted. When req=1, latch addr/we/wdata, then:
    - addr==16'hFFFF: go to DONE. A write latches wdata into hex_val at that edge. A read latches the switch value into rdata at that edge.
    - Otherwise: load wait counter with WAIT_CYCLES-1 and go to MEM_ACC.
  - MEM_ACC: ce_n=0, ub_n=0, lb_n=0 (word access only).
    - Reads: oe_n=0, we_n=1.
    - Writes: we_n=0, oe_n=1, mem_dout=latched wdata, mem_dout_en=1.
    - Counter decrements each cycle. At counter==0, a read captures mem_din into rdata and the FSM goes to DONE.
  - DONE: strobes deasserted, ready=1 for exactly this cycle; then go to IDLE. req is ignored in DONE.
- req still high in IDLE after DONE starts a new access. The CPU drops req on ready when it does not want a repeat.
- rdata holds its last value until the next completed read. Writes never change rdata.
- hex_val changes only on an accepted write to 16'hFFFF.
- mem_addr is registered from the latched addr and is stable for the whole MEM_ACC window.

## Timing
- Reset values: state=IDLE, ready=0, rdata=0, hex_val=0, mem_addr=0, mem_dout=0, mem_dout_en=0, all *_n strobes=1, counter=0.
- I/O access: req sampled at edge 0; ready is high in cycle 1. Latency is 1.
- SRAM access: req sampled at edge 0; strobes are active for cycles 1..WAIT_CYCLES; ready is high in cycle WAIT_CYCLES+1.
- Back-to-back: with req held high, the minimum issue interval is WAIT_CYCLES+2 cycles (SRAM) or 2 cycles (I/O).
- Reset asserted in any state: at the next edge, return to IDLE with reset values. No partial write completes, and hex_val is cleared.
- Reset and req in the same cycle: reset wins and the request is dropped.
- Counter is 4 bits and never wraps: it is only decremented while non-zero.

## Configuration
- SW_SYNC_EN defined: switches pass through a two-flop synchronizer before the I/O read mux. A switch change becomes readable 2 cycles later. The synchronizer flops reset to 0.
- SW_SYNC_EN undefined: switches feed the read mux directly, with zero added latency.

## Structure
- Shared package slc3_pkg holds:
  - IO_ADDR = 16'hFFFF.
  - Typedef bridge_state_t {IDLE, MEM_ACC, DONE}.
  - WORD_W = 16 and MEM_ADDR_W = 20.
- One sub-module, sw_sync: a parameterised-width two-flop synchronizer. It is instantiated only under SW_SYNC_EN.

## Test plan
- Reset, then idle 5 cycles: all strobes=1, ready=0, hex_val=0, rdata=0.
- Write 16'hBEEF to 16'hFFFF: ready in cycle 1, hex_val=16'hBEEF, no SRAM strobe ever asserted.
- switches=16'h1234, read 16'hFFFF: rdata=16'h1234 with ready after 1 cycle (3 cycles total when SW_SYNC_EN is defined and switches changed just before the request).
- WAIT_CYCLES=2:
  - Write 16'hA5A5 to 16'h0040: mem_addr=20'h00040, we_n=0 and mem_dout_en=1 for exactly 2 cycles, ready in cycle 3.
  - Then read 16'h0040 with a model returning 16'hA5A5: rdata=16'hA5A5 at ready.
- Assert Reset in the second MEM_ACC cycle of a write: next cycle all strobes=1, state IDLE, no ready pulse, hex_val=0.
- Hold req=1 across two reads: two ready pulses exactly WAIT_CYCLES+2 cycles apart, with no strobe overlap with DONE.
